shift_issue_queue: RTL and testbench
====================================

Name: shift_issue_queue

Overview:
- Issue stage directly upstream of the shift ALU.
- Buffers decoded shift operations from the decoder in a small FIFO and drives the ALU operand, amount, operation and enable lines, one op per cycle.
- Emits a result-valid strobe and tag aligned with the ALU's registered output, one cycle after issue, so writeback can capture aluout_shift with the matching tag.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
TAG_W, 4, width of the destination/tag field carried with each op

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous reset, active-low (0 = reset)
flush  input  1  synchronous queue clear, active-high
dec_valid  input  1  decoder presents an op
dec_ready  output  1  queue can accept an op
dec_op  input  3  shift operation code
dec_operand  input  32  value to shift
dec_shamt  input  5  shift amount
dec_tag  input  TAG_W  destination tag
wb_ready  input  1  writeback can take a result in the following cycle
alu_enable  output  1  issue strobe to ALU
alu_in  output  32  operand to ALU
alu_shift  output  5  amount to ALU
alu_shift_operation  output  3  operation to ALU
res_valid  output  1  aluout_shift is valid this cycle
res_tag  output  TAG_W  tag of the result in this cycle
occupancy  output  log2(DEPTH)+1  entries currently held

Behaviour:
- Reset (RESET=0 at the edge):
  - All outputs go to 0, except dec_ready, which is 1 from the first cycle after reset.
  - FIFO is empty; read/write pointers are 0.
  - Reset mid-operation discards all queued entries and any pending res_valid.
- Push:
  - Occurs when dec_valid and dec_ready are both 1.
  - dec_ready = (occupancy != DEPTH); it is a registered-state function, not combinational on pop.
  - When full, no push is taken even if a pop occurs in the same cycle.
- Issue:
  - Condition: FIFO non-empty, wb_ready=1, flush=0.
  - Registered outputs for that cycle: alu_enable=1, alu_in/alu_shift/alu_shift_operation = head entry. The head entry pops.
  - Otherwise alu_enable=0 and the alu_* data outputs hold their last values.
- No bypass:
  - An op pushed in cycle N issues at the earliest in cycle N+1 (alu_enable high).
  - Its result is valid in cycle N+2: res_valid=1, res_tag = tag of the op.
- res_valid:
  - Pulses for exactly one cycle per issue, the cycle after alu_enable.
  - Writeback must capture it; wb_ready sampled at issue is the only backpressure.
- Simultaneous push and issue: occupancy is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- occupancy range is 0..DEPTH.
- flush=1:
  - Empties the FIFO and forces alu_enable=0 next cycle.
  - Suppresses the res_valid of an op issued in the same cycle as flush.
  - A push in the flush cycle is dropped.
  - flush has priority over push and issue. RESET has priority over flush.
- Back-to-back issue: sustained one op per cycle while non-empty and wb_ready=1.
- Opcode legality: legal codes are 000, 001, 010, 011. Handling of illegal codes depends on the optional feature below.

Optional Feature:
SHIFT_ILLEGAL_OP_CHECK_EN
- Defined:
  - A head entry whose op is greater than 011 pops without asserting alu_enable.
  - One cycle later, res_valid=1 with res_tag = its tag, and an extra output res_illegal=1.
  - res_illegal exists only when the macro is defined and resets to 0.
- Undefined:
  - Illegal ops issue normally with alu_enable=1.
  - res_valid still pulses; the ALU leaves aluout_shift unchanged, so the result is undefined.
  - No res_illegal port.

Test Plan:
- Reset: hold RESET=0 2 cycles with dec_valid=1 -> occupancy=0, alu_enable=0, res_valid=0; dec_ready=1 one cycle after RESET=1.
- Single op: push op=000, operand=0x0000_00F1, shamt=4, tag=3, wb_ready=1 -> alu_enable with alu_in=0xF1, alu_shift=4 next cycle; res_valid=1, res_tag=3 the cycle after.
- Fill/backpressure: wb_ready=0, push 5 ops with DEPTH=4 -> dec_ready=0 after the 4th, 5th held by decoder, occupancy=4. Then wb_ready=1 -> 4 consecutive alu_enable pulses in FIFO order, tags 0,1,2,3.
- Simultaneous push/issue at occupancy=2 -> occupancy stays 2; run 2*DEPTH ops -> pointers wrap, tag order preserved.
- Flush: occupancy=3, issue in the same cycle as flush=1 -> occupancy=0 next cycle, no res_valid, no further alu_enable.
- Illegal op 101, tag=7: with SHIFT_ILLEGAL_OP_CHECK_EN -> no alu_enable, res_valid=1, res_illegal=1, res_tag=7. Without the macro -> alu_enable=1, res_valid=1.

Source files
------------

// File: rtl/shift_issue_queue.sv
// Issue queue in front of the shift ALU: buffers decoded ops and strobes a result valid/tag
// one cycle after each issue. Optional macro SHIFT_ILLEGAL_OP_CHECK_EN retires illegal opcodes unissued.
module shift_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                    CLOCK,
   input  logic                    RESET,
   input  logic                    flush,
   input  logic                    dec_valid,
   output logic                    dec_ready,
   input  logic [2:0]              dec_op,
   input  logic [31:0]             dec_operand,
   input  logic [4:0]              dec_shamt,
   input  logic [TAG_W-1:0]        dec_tag,
   input  logic                    wb_ready,
   output logic                    alu_enable,
   output logic [31:0]             alu_in,
   output logic [4:0]              alu_shift,
   output logic [2:0]              alu_shift_operation,
   output logic                    res_valid,
   output logic [TAG_W-1:0]        res_tag,
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
   output logic                    res_illegal,
`endif
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [2:0]       op_mem      [DEPTH];
   logic [31:0]      operand_mem [DEPTH];
   logic [4:0]       shamt_mem   [DEPTH];
   logic [TAG_W-1:0] tag_mem     [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   logic             push;
   logic             pop;
   logic             head_legal;

   logic             issue_vld_p1;
   logic [TAG_W-1:0] issue_tag_p1;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
   logic             issue_illegal_p1;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction
`endif

   // ready depends only on the registered count, never on the same-cycle pop
   always_comb begin
      dec_ready  = (count != FULL_CNT);
      push       = dec_valid && dec_ready && !flush;
      pop        = (count != '0) && wb_ready && !flush;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      head_legal = op_is_legal(op_mem[rd_ptr]);
`else
      head_legal = 1'b1;
`endif
   end

   assign occupancy = count;

   // ---- stage p0: queue storage
   always_ff @(posedge CLOCK) begin
      if (push) begin
         op_mem[wr_ptr]      <= dec_op;
         operand_mem[wr_ptr] <= dec_operand;
         shamt_mem[wr_ptr]   <= dec_shamt;
         tag_mem[wr_ptr]     <= dec_tag;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---- stage p1: issue to ALU
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         alu_enable          <= 1'b0;
         alu_in              <= '0;
         alu_shift           <= '0;
         alu_shift_operation <= '0;
         issue_vld_p1        <= 1'b0;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
         issue_illegal_p1    <= 1'b0;
`endif
      end else begin
         alu_enable   <= pop && head_legal;
         issue_vld_p1 <= pop;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
         issue_illegal_p1 <= pop && !head_legal;
`endif
         if (pop && head_legal) begin
            alu_in              <= operand_mem[rd_ptr];
            alu_shift           <= shamt_mem[rd_ptr];
            alu_shift_operation <= op_mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (pop) issue_tag_p1 <= tag_mem[rd_ptr];
   end

   // ---- stage p2: result strobe aligned with the ALU's registered output
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         res_valid   <= 1'b0;
         res_tag     <= '0;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
         res_illegal <= 1'b0;
`endif
      end else begin
         res_valid <= issue_vld_p1 && !flush;
         if (issue_vld_p1) res_tag <= issue_tag_p1;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
         res_illegal <= issue_vld_p1 && issue_illegal_p1 && !flush;
`endif
      end
   end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Randomized bench for shift_issue_queue against a queue-based transaction model.
// Honours SHIFT_ILLEGAL_OP_CHECK_EN the same way as the design.
module tb_shift_issue_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int OW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [2:0]       op;
      logic [31:0]      operand;
      logic [4:0]       shamt;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic             CLOCK = 1'b0;
   logic             RESET = 1'b0;
   logic             flush = 1'b0;
   logic             dec_valid = 1'b0;
   logic             dec_ready;
   logic [2:0]       dec_op = '0;
   logic [31:0]      dec_operand = '0;
   logic [4:0]       dec_shamt = '0;
   logic [TAG_W-1:0] dec_tag = '0;
   logic             wb_ready = 1'b0;
   logic             alu_enable;
   logic [31:0]      alu_in;
   logic [4:0]       alu_shift;
   logic [2:0]       alu_shift_operation;
   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic [OW-1:0]    occupancy;
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
   logic             res_illegal;
`endif

   shift_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
      .dec_operand(dec_operand), .dec_shamt(dec_shamt), .dec_tag(dec_tag),
      .wb_ready(wb_ready), .alu_enable(alu_enable), .alu_in(alu_in),
      .alu_shift(alu_shift), .alu_shift_operation(alu_shift_operation),
      .res_valid(res_valid), .res_tag(res_tag),
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      .res_illegal(res_illegal),
`endif
      .occupancy(occupancy)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: contents of the queue plus the visible outputs
   entry_t           q[$];
   logic             m_alu_en, m_res_valid, m_res_ill;
   logic [31:0]      m_alu_in;
   logic [4:0]       m_alu_shift;
   logic [2:0]       m_alu_op;
   logic [TAG_W-1:0] m_res_tag;
   logic             pend_v, pend_ill;
   logic [TAG_W-1:0] pend_tag;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic legal_op(input logic [2:0] op);
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      return op <= 3'd3;
`else
      return 1'b1;
`endif
   endfunction

   function automatic entry_t mk(input logic [2:0] op, input logic [31:0] operand,
                                 input logic [4:0] shamt, input logic [TAG_W-1:0] tag);
      entry_t e;
      e.op = op; e.operand = operand; e.shamt = shamt; e.tag = tag;
      return e;
   endfunction

   function automatic entry_t rnd_entry(input logic legal_only);
      logic [2:0] op;
      op = legal_only ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      return mk(op, $urandom, 5'($urandom), TAG_W'($urandom));
   endfunction

   task automatic model_update(input logic rst_n, input logic fl, input logic dv,
                               input entry_t e, input logic wbr);
      entry_t h;
      logic   full, do_issue;
      if (!rst_n) begin
         q.delete();
         m_alu_en = 0; m_alu_in = 0; m_alu_shift = 0; m_alu_op = 0;
         m_res_valid = 0; m_res_tag = 0; m_res_ill = 0;
         pend_v = 0; pend_ill = 0; pend_tag = 0;
      end else begin
         full        = (q.size() == DEPTH);
         m_res_valid = pend_v && !fl;
         m_res_ill   = pend_v && pend_ill && !fl;
         if (pend_v) m_res_tag = pend_tag;
         if (fl) begin
            q.delete();
            m_alu_en = 0;
            pend_v   = 0;
         end else begin
            do_issue = (q.size() > 0) && wbr;
            if (do_issue) begin
               h        = q.pop_front();
               pend_v   = 1;
               pend_tag = h.tag;
               pend_ill = !legal_op(h.op);
               m_alu_en = legal_op(h.op);
               if (legal_op(h.op)) begin
                  m_alu_in = h.operand; m_alu_shift = h.shamt; m_alu_op = h.op;
               end
            end else begin
               pend_v   = 0;
               m_alu_en = 0;
            end
            if (dv && !full) q.push_back(e);
         end
      end
   endtask

   task automatic compare_outputs();
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("dec_ready", 64'(dec_ready), 64'(q.size() != DEPTH));
      check("alu_enable", 64'(alu_enable), 64'(m_alu_en));
      check("alu_in", 64'(alu_in), 64'(m_alu_in));
      check("alu_shift", 64'(alu_shift), 64'(m_alu_shift));
      check("alu_op", 64'(alu_shift_operation), 64'(m_alu_op));
      check("res_valid", 64'(res_valid), 64'(m_res_valid));
      if (m_res_valid) check("res_tag", 64'(res_tag), 64'(m_res_tag));
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      check("res_illegal", 64'(res_illegal), 64'(m_res_ill));
`endif
   endtask

   // drive one cycle of inputs at the falling edge, then check after the next rising edge
   task automatic step(input logic rst_n, input logic fl, input logic dv,
                       input entry_t e, input logic wbr);
      RESET = rst_n; flush = fl; dec_valid = dv; wb_ready = wbr;
      dec_op = e.op; dec_operand = e.operand; dec_shamt = e.shamt; dec_tag = e.tag;
      model_update(rst_n, fl, dv, e, wbr);
      @(negedge CLOCK);
      compare_outputs();
   endtask

   entry_t idle_e;

   initial begin
      idle_e = mk(3'd0, 32'd0, 5'd0, '0);

      // reset held two cycles with the decoder presenting an op
      step(0, 0, 1, rnd_entry(1), 1);
      step(0, 0, 1, rnd_entry(1), 1);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_alu_en", 64'(alu_enable), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      step(1, 0, 0, idle_e, 1);
      check("rst_dec_ready", 64'(dec_ready), 64'd1);

      // single op
      step(1, 0, 1, mk(3'd0, 32'h0000_00F1, 5'd4, 4'd3), 1);
      step(1, 0, 0, idle_e, 1);
      check("single_alu_en", 64'(alu_enable), 64'd1);
      check("single_alu_in", 64'(alu_in), 64'hF1);
      check("single_alu_shift", 64'(alu_shift), 64'd4);
      step(1, 0, 0, idle_e, 1);
      check("single_res_valid", 64'(res_valid), 64'd1);
      check("single_res_tag", 64'(res_tag), 64'd3);
      step(1, 0, 0, idle_e, 1);

      // fill under backpressure, then drain in order
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, mk(3'($urandom_range(0, 3)), $urandom, 5'($urandom), TAG_W'(i)), 0);
         if (i == 3) check("fill_dec_ready", 64'(dec_ready), 64'd0);
      end
      check("fill_occ", 64'(occupancy), 64'd4);
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 0, idle_e, 1);
         if (k < 4) check("drain_alu_en", 64'(alu_enable), 64'd1);
         if (k >= 1 && k <= 4) check("drain_res_tag", 64'(res_tag), 64'(k - 1));
      end

      // simultaneous push and issue at occupancy 2, long enough to wrap pointers
      step(1, 0, 1, rnd_entry(1), 0);
      step(1, 0, 1, rnd_entry(1), 0);
      for (int k = 0; k < 2 * DEPTH; k++) begin
         step(1, 0, 1, rnd_entry(1), 1);
         check("steady_occ", 64'(occupancy), 64'd2);
      end
      for (int k = 0; k < 4; k++) step(1, 0, 0, idle_e, 1);

      // flush in the cycle of an issued op
      for (int k = 0; k < 3; k++) step(1, 0, 1, rnd_entry(1), 0);
      step(1, 0, 0, idle_e, 1);
      check("pre_flush_alu_en", 64'(alu_enable), 64'd1);
      step(1, 1, 1, rnd_entry(1), 1);
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_res_valid", 64'(res_valid), 64'd0);
      check("flush_alu_en", 64'(alu_enable), 64'd0);
      step(1, 0, 0, idle_e, 1);
      check("post_flush_res_valid", 64'(res_valid), 64'd0);
      check("post_flush_alu_en", 64'(alu_enable), 64'd0);

      // illegal opcode 101
      step(1, 0, 1, mk(3'b101, 32'h1234_5678, 5'd9, 4'd7), 1);
      step(1, 0, 0, idle_e, 1);
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      check("illegal_alu_en", 64'(alu_enable), 64'd0);
`else
      check("illegal_alu_en", 64'(alu_enable), 64'd1);
`endif
      step(1, 0, 0, idle_e, 1);
      check("illegal_res_valid", 64'(res_valid), 64'd1);
      check("illegal_res_tag", 64'(res_tag), 64'd7);
`ifdef SHIFT_ILLEGAL_OP_CHECK_EN
      check("illegal_flag", 64'(res_illegal), 64'd1);
`endif

      // reset mid-operation
      for (int k = 0; k < 3; k++) step(1, 0, 1, rnd_entry(1), 0);
      step(1, 0, 1, rnd_entry(1), 1);
      step(0, 0, 1, rnd_entry(1), 1);
      check("midrst_occ", 64'(occupancy), 64'd0);
      check("midrst_res_valid", 64'(res_valid), 64'd0);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 9) < 6), rnd_entry($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) < 7));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
